// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: sequencer states and
// the canonical NOP (addi x0,x0,0) loaded into IF/ID on a flush.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection: the instruction in ID reads the
// destination of a load currently in EX (x0 never creates a dependency).
module load_use_detect (
  input  logic [4:0] IF_ID_Rs1,
  input  logic [4:0] IF_ID_Rs2,
  input  logic       IF_ID_UseRs1,
  input  logic       IF_ID_UseRs2,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rd,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = IF_ID_UseRs1 && (IF_ID_Rs1 == ID_EX_Rd);
    rs2_hit  = IF_ID_UseRs2 && (IF_ID_Rs2 == ID_EX_Rd);
    load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles,
// redirect flush sequencing, data-memory freeze, watchdog and stall counter.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_BUBBLES = 2,
  parameter int unsigned MEM_TIMEOUT      = 64,
  parameter int unsigned CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic             IF_ID_UseRs1,
  input  logic             IF_ID_UseRs2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             EX_Redirect,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             DMem_Ready,
  output logic             PCWrite,
  output logic             IF_ID_Stall,
  output logic             IF_ID_Flush,
  output logic             Control_Sig_Stall,
  output logic             ID_EX_Flush,
  output logic             Pipe_Freeze,
  output logic             MEM_WB_Flush,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Stall_Count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [2:0]        BUB_INIT  = 3'(REDIRECT_BUBBLES - 1);

  state_t            state;
  state_t            saved_state;
  state_t            eff_state;
  logic [2:0]        bub_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_busy;
  logic              load_use;

  load_use_detect u_load_use_detect (
    .IF_ID_Rs1    (IF_ID_Rs1),
    .IF_ID_Rs2    (IF_ID_Rs2),
    .IF_ID_UseRs1 (IF_ID_UseRs1),
    .IF_ID_UseRs2 (IF_ID_UseRs2),
    .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_Rd     (ID_EX_Rd),
    .load_use     (load_use)
  );

  // The first unfrozen cycle behaves as the state that was interrupted.
  always_comb begin
    mem_busy  = (EX_MEM_MemRead || EX_MEM_MemWrite) && !DMem_Ready;
    eff_state = (state == MEM_WAIT) ? saved_state : state;
  end

  always_comb begin
    PCWrite           = 1'b0;
    IF_ID_Stall       = 1'b0;
    IF_ID_Flush       = 1'b0;
    Control_Sig_Stall = 1'b0;
    ID_EX_Flush       = 1'b0;
    Pipe_Freeze       = 1'b0;
    MEM_WB_Flush      = 1'b0;
    if (rst) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      MEM_WB_Flush = 1'b1;
    end else if (mem_busy) begin
      IF_ID_Stall  = 1'b1;
      Pipe_Freeze  = 1'b1;
      MEM_WB_Flush = 1'b1;
    end else if (EX_Redirect) begin
      PCWrite     = 1'b1;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (eff_state == REDIRECT) begin
      PCWrite     = 1'b1;
      IF_ID_Flush = 1'b1;
    end else if (load_use) begin
      IF_ID_Stall       = 1'b1;
      Control_Sig_Stall = 1'b1;
    end else begin
      PCWrite = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      saved_state <= RUN;
      bub_cnt     <= '0;
      wait_cnt    <= '0;
      Mem_Timeout <= 1'b0;
      Stall_Count <= '0;
    end else begin
      if (!PCWrite && (Stall_Count != '1))
        Stall_Count <= Stall_Count + CNT_W'(1);
      if (mem_busy) begin
        state       <= MEM_WAIT;
        saved_state <= eff_state;
        if (wait_cnt != WAIT_MAX)
          wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt >= WAIT_LAST)
          Mem_Timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
        if (EX_Redirect) begin
          if (REDIRECT_BUBBLES > 1) begin
            bub_cnt <= BUB_INIT;
            state   <= REDIRECT;
          end else begin
            state <= RUN;
          end
        end else if (eff_state == REDIRECT) begin
          bub_cnt <= bub_cnt - 3'd1;
          state   <= (bub_cnt == 3'd1) ? RUN : REDIRECT;
        end else begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed hazard scenarios
// followed by randomized traffic, checked against a cycle-level reference model.
module tb_pipeline_hazard_controller;

  localparam int unsigned BUB = 2;
  localparam int unsigned TMO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
  logic        IF_ID_UseRs1, IF_ID_UseRs2, ID_EX_MemRead, EX_Redirect;
  logic        EX_MEM_MemRead, EX_MEM_MemWrite, DMem_Ready;
  logic        PCWrite, IF_ID_Stall, IF_ID_Flush, Control_Sig_Stall;
  logic        ID_EX_Flush, Pipe_Freeze, MEM_WB_Flush, Mem_Timeout;
  logic [31:0] Stall_Count;

  pipeline_hazard_controller #(
    .REDIRECT_BUBBLES(BUB),
    .MEM_TIMEOUT     (TMO),
    .CNT_W           (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .IF_ID_Rs1        (IF_ID_Rs1),
    .IF_ID_Rs2        (IF_ID_Rs2),
    .IF_ID_UseRs1     (IF_ID_UseRs1),
    .IF_ID_UseRs2     (IF_ID_UseRs2),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_Rd         (ID_EX_Rd),
    .EX_Redirect      (EX_Redirect),
    .EX_MEM_MemRead   (EX_MEM_MemRead),
    .EX_MEM_MemWrite  (EX_MEM_MemWrite),
    .DMem_Ready       (DMem_Ready),
    .PCWrite          (PCWrite),
    .IF_ID_Stall      (IF_ID_Stall),
    .IF_ID_Flush      (IF_ID_Flush),
    .Control_Sig_Stall(Control_Sig_Stall),
    .ID_EX_Flush      (ID_EX_Flush),
    .Pipe_Freeze      (Pipe_Freeze),
    .MEM_WB_Flush     (MEM_WB_Flush),
    .Mem_Timeout      (Mem_Timeout),
    .Stall_Count      (Stall_Count)
  );

  always #5 clk = ~clk;

  // ctrl = {PCWrite, IF_ID_Stall, IF_ID_Flush, Control_Sig_Stall, ID_EX_Flush, Pipe_Freeze, MEM_WB_Flush}
  typedef struct {
    logic [6:0]  ctrl;
    logic        mt;
    logic [31:0] sc;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: remaining flush-only cycles after a redirect, consecutive
  // busy cycles, sticky watchdog flag and the PC-hold cycle total.
  int      m_bub  = 0;
  int      m_wait = 0;
  bit      m_to   = 1'b0;
  longint  m_sc   = 0;

  task automatic step(input logic r, input logic ld_ex, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic redir,
                      input logic ld_mem, input logic st_mem, input logic rdy);
    exp_t e;
    bit   busy, lu, pcw;
    rst = r; ID_EX_MemRead = ld_ex; ID_EX_Rd = rd; IF_ID_Rs1 = rs1; IF_ID_Rs2 = rs2;
    IF_ID_UseRs1 = u1; IF_ID_UseRs2 = u2; EX_Redirect = redir;
    EX_MEM_MemRead = ld_mem; EX_MEM_MemWrite = st_mem; DMem_Ready = rdy;
    e.mt  = m_to;
    e.sc  = m_sc[31:0];
    e.cyc = cyc;
    busy = (ld_mem || st_mem) && !rdy;
    lu   = ld_ex && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (r) begin
      e.ctrl = 7'b0010101;
      m_bub = 0; m_wait = 0; m_to = 1'b0; m_sc = 0;
    end else begin
      if (busy) begin
        e.ctrl = 7'b0100011;
        m_wait++;
        if (m_wait >= TMO) m_to = 1'b1;
      end else begin
        m_wait = 0;
        if (redir) begin
          e.ctrl = 7'b1010100;
          m_bub  = BUB - 1;
        end else if (m_bub > 0) begin
          e.ctrl = 7'b1010000;
          m_bub--;
        end else if (lu) begin
          e.ctrl = 7'b0101000;
        end else begin
          e.ctrl = 7'b1000000;
        end
      end
      pcw = e.ctrl[6];
      if (!pcw && m_sc < 64'hFFFF_FFFF) m_sc++;
    end
    q.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: every cycle the DUT presents its control word; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({PCWrite, IF_ID_Stall, IF_ID_Flush, Control_Sig_Stall, ID_EX_Flush, Pipe_Freeze, MEM_WB_Flush} !== e.ctrl) begin
          errors++;
          $display("FAIL ctrl cyc=%0d got=%b want=%b", e.cyc,
                   {PCWrite, IF_ID_Stall, IF_ID_Flush, Control_Sig_Stall, ID_EX_Flush, Pipe_Freeze, MEM_WB_Flush}, e.ctrl);
        end
        checks++;
        if (Mem_Timeout !== e.mt) begin
          errors++;
          $display("FAIL mem_timeout cyc=%0d got=%b want=%b", e.cyc, Mem_Timeout, e.mt);
        end
        checks++;
        if (Stall_Count !== e.sc) begin
          errors++;
          $display("FAIL stall_count cyc=%0d got=%0d want=%0d", e.cyc, Stall_Count, e.sc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ID_EX_MemRead = 0; ID_EX_Rd = 0; IF_ID_Rs1 = 0; IF_ID_Rs2 = 0;
    IF_ID_UseRs1 = 0; IF_ID_UseRs2 = 0; EX_Redirect = 0;
    EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0; DMem_Ready = 1;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // load-use on Rs1, then the load has moved on
    step(0, 1, 5, 5, 7, 1, 1, 0, 0, 0, 1);
    step(0, 0, 5, 5, 7, 1, 1, 0, 0, 0, 1);
    // load-use on Rs2
    step(0, 1, 9, 3, 9, 1, 1, 0, 0, 0, 1);
    step(0, 0, 9, 3, 9, 1, 1, 0, 0, 0, 1);
    // Rd=x0 and unused Rs1: no hazard
    step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 5, 5, 7, 0, 1, 0, 0, 0, 1);
    // redirect pulse
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle(2);
    // redirect and load-use together: flush only
    step(0, 1, 6, 6, 0, 1, 0, 1, 0, 0, 1);
    step(0, 1, 6, 6, 0, 1, 0, 0, 0, 0, 1);
    idle(1);
    // store waiting 3 cycles with a redirect held in EX
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    idle(3);
    // watchdog: load stuck for the full timeout window
    for (int i = 0; i < TMO; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(3);
    // reset during the redirect sequence
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) != 0));
    end
    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
